// File: rtl/sparse_synapse_accum_if.sv
// Bus bundle for sparse_synapse_accum: weight-write port, spike-vector input,
// current-word output and status.
interface sparse_synapse_accum_if #(
    parameter int N_IN      = 8,
    parameter int W_WIDTH   = 8,
    parameter int CUR_WIDTH = 8
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                        w_we;
    logic [IW-1:0]               w_addr;
    logic signed [W_WIDTH-1:0]   w_data;
    // valid/ready: a word moves on a rising edge where both are high; valid,
    // once raised, holds its payload stable until that edge.
    logic                        in_valid;
    logic                        in_ready;
    logic [N_IN-1:0]             in_spikes;
    logic                        out_valid;
    logic                        out_ready;
    logic [CUR_WIDTH-1:0]        out_current;
    logic                        busy;
    logic [15:0]                 skip_count;
    logic [1:0]                  fsm_state;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_spikes, out_ready,
        input  in_ready, out_valid, out_current, busy, skip_count, fsm_state
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_spikes, out_ready,
        output in_ready, out_valid, out_current, busy, skip_count, fsm_state
    );
endinterface

// File: rtl/sparse_synapse_accum.sv
// Sparsity-aware synaptic accumulator: visits only the set bits of a spike vector
// and emits a clamped current word. Optional skip statistics via SPARSE_STATS_EN.
module sparse_synapse_accum #(
    parameter int N_IN      = 8,
    parameter int W_WIDTH   = 8,
    parameter int CUR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sparse_synapse_accum_if.slave  io_bus
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int AW = W_WIDTH + IW + 1;
    localparam int CW = (AW > CUR_WIDTH + 1) ? AW : CUR_WIDTH + 1;
    localparam logic [CW-1:0] CUR_MAX_W = {{(CW-CUR_WIDTH){1'b0}}, {CUR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [W_WIDTH-1:0] r_weight [N_IN];
    logic [N_IN-1:0]           r_pending;
    logic signed [AW-1:0]      r_acc;
    logic                      r_out_valid;
    logic                      r_in_ready;
    logic                      r_busy;
    logic [CUR_WIDTH-1:0]      r_out_current;

    logic [IW-1:0]             w_idx;
    logic                      w_last;
    logic signed [W_WIDTH-1:0] w_wsel;
    logic signed [AW-1:0]      w_acc_next;
    logic [CW-1:0]             w_acc_wide;
    logic [CUR_WIDTH-1:0]      w_clamped;
    logic                      w_accept;

    assign w_accept = r_in_ready & io_bus.in_valid;

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (r_pending[i]) w_idx = IW'(i);
        end
    end

    assign w_last     = ((r_pending & (r_pending - N_IN'(1))) == '0);
    assign w_wsel     = r_weight[w_idx];
    assign w_acc_next = r_acc + {{(AW-W_WIDTH){w_wsel[W_WIDTH-1]}}, w_wsel};
    assign w_acc_wide = CW'(w_acc_next);

    always_comb begin
        if (w_acc_wide[CW-1])
            w_clamped = '0;
        else if (w_acc_wide > CUR_MAX_W)
            w_clamped = {CUR_WIDTH{1'b1}};
        else
            w_clamped = w_acc_wide[CUR_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_acc         <= '0;
            r_out_valid   <= 1'b0;
            r_out_current <= '0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            for (int i = 0; i < N_IN; i++) r_weight[i] <= '0;
        end else begin
            // The SCAN read above samples the pre-edge array, so a same-cycle write is not seen.
            if (io_bus.w_we && (32'(io_bus.w_addr) < N_IN))
                r_weight[io_bus.w_addr] <= io_bus.w_data;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pending  <= io_bus.in_spikes;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (io_bus.in_spikes != '0) begin
                            r_state <= S_SCAN;
                        end else begin
                            r_state       <= S_OUT;
                            r_out_valid   <= 1'b1;
                            r_out_current <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    r_acc            <= w_acc_next;
                    r_pending[w_idx] <= 1'b0;
                    if (w_last) begin
                        r_state       <= S_OUT;
                        r_out_valid   <= 1'b1;
                        r_out_current <= w_clamped;
                    end
                end
                S_OUT: begin
                    if (io_bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPARSE_STATS_EN
    logic [15:0] r_skip;
    logic [15:0] w_popcnt;
    logic [16:0] w_skip_sum;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < N_IN; i++) w_popcnt = w_popcnt + 16'(io_bus.in_spikes[i]);
    end

    assign w_skip_sum = {1'b0, r_skip} + {1'b0, (16'(N_IN) - w_popcnt)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_skip <= '0;
        else if (w_accept)
            r_skip <= w_skip_sum[16] ? 16'hFFFF : w_skip_sum[15:0];
    end

    assign io_bus.skip_count = r_skip;
`else
    assign io_bus.skip_count = 16'd0;
`endif

    assign io_bus.in_ready    = r_in_ready;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_current = r_out_current;
    assign io_bus.busy        = r_busy;
    assign io_bus.fsm_state   = r_state;
endmodule

// File: tb/tb_sparse_synapse_accum.sv
// Directed self-checking bench for sparse_synapse_accum (default 8x8x8 build).
module tb_sparse_synapse_accum;
    localparam int N_IN      = 8;
    localparam int W_WIDTH   = 8;
    localparam int CUR_WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sparse_synapse_accum_if #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .CUR_WIDTH(CUR_WIDTH)) bus ();

    sparse_synapse_accum #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .CUR_WIDTH(CUR_WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic init_inputs();
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.in_valid  = 1'b0;
        bus.in_spikes = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic write_weight(input int addr, input int data);
        bus.w_we   = 1'b1;
        bus.w_addr = 3'(addr);
        bus.w_data = 8'(data);
        @(posedge clk); #1;
        bus.w_we   = 1'b0;
    endtask

    // Latency is counted in cycles after the accept edge; -2 means never accepted, -1 never answered.
    task automatic send_vector(input logic [N_IN-1:0] v, output int lat, output bit saw_scan);
        int n;
        lat      = -2;
        saw_scan = 1'b0;
        n        = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready) begin
            bus.in_valid  = 1'b1;
            bus.in_spikes = v;
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                if (bus.fsm_state == 2'd1) saw_scan = 1'b1;
                if (bus.out_valid) begin
                    lat = k;
                    break;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic pop_output();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_current !== 8'd0) begin errors++; $display("FAIL reset_out_current: got %0d want 0", bus.out_current); end
        checks++; if (bus.skip_count !== 16'd0) begin errors++; $display("FAIL reset_skip_count: got %0d want 0", bus.skip_count); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sparse();
        int lat; bit scan;
        for (int i = 0; i < N_IN; i++) write_weight(i, i + 1);
        send_vector(8'b0000_0101, lat, scan);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sparse05_latency: got %0d want 2", lat); end
        checks++; if (bus.out_current !== 8'd4) begin errors++; $display("FAIL sparse05_current: got %0d want 4", bus.out_current); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sparse05_busy: got %b want 1", bus.busy); end
        pop_output();
        send_vector(8'b1000_0110, lat, scan);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sparse86_latency: got %0d want 3", lat); end
        checks++; if (bus.out_current !== 8'd13) begin errors++; $display("FAIL sparse86_current: got %0d want 13", bus.out_current); end
        pop_output();
    endtask

    task automatic test_empty();
        int lat; bit scan;
        send_vector(8'h00, lat, scan);
        checks++; if (lat !== 0) begin errors++; $display("FAIL empty_latency: got %0d want 0", lat); end
        checks++; if (bus.out_current !== 8'd0) begin errors++; $display("FAIL empty_current: got %0d want 0", bus.out_current); end
        checks++; if (scan !== 1'b0) begin errors++; $display("FAIL empty_scan_entered: got %b want 0", scan); end
        pop_output();
    endtask

    task automatic test_clamp();
        int lat; bit scan;
        for (int i = 0; i < N_IN; i++) write_weight(i, 127);
        send_vector(8'hFF, lat, scan);
        checks++; if (lat !== 8) begin errors++; $display("FAIL clamp_hi_latency: got %0d want 8", lat); end
        checks++; if (bus.out_current !== 8'd255) begin errors++; $display("FAIL clamp_hi_current: got %0d want 255", bus.out_current); end
        pop_output();
        write_weight(0, -50);
        write_weight(1, 20);
        send_vector(8'h03, lat, scan);
        checks++; if (bus.out_current !== 8'd0) begin errors++; $display("FAIL clamp_lo_current: got %0d want 0", bus.out_current); end
        pop_output();
        send_vector(8'h07, lat, scan);
        checks++; if (bus.out_current !== 8'd97) begin errors++; $display("FAIL clamp_mid_current: got %0d want 97", bus.out_current); end
        pop_output();
    endtask

    task automatic test_backpressure();
        int lat; bit scan;
        send_vector(8'h02, lat, scan);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d want 1", lat); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_current !== 8'd20 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b cur=%0d in_ready=%b want 1/20/0",
                         c, bus.out_valid, bus.out_current, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        pop_output();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_weight_write_in_scan();
        int lat; bit scan;
        int n;
        write_weight(0, 10);
        write_weight(1, 10);
        bus.in_valid  = 1'b1;
        bus.in_spikes = 8'h03;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.w_we      = 1'b1;
        bus.w_addr    = 3'd0;
        bus.w_data    = 8'd100;
        @(posedge clk); #1;
        bus.w_we      = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (bus.out_current !== 8'd20 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ww_old_weight: got cur=%0d valid=%b want 20/1", bus.out_current, bus.out_valid); end
        pop_output();
        send_vector(8'h01, lat, scan);
        checks++; if (bus.out_current !== 8'd100) begin errors++; $display("FAIL ww_new_weight: got %0d want 100", bus.out_current); end
        pop_output();
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts       = 0;
        bus.out_ready = 1'b1;
        bus.in_spikes = 8'h01;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.in_ready) accepts++;
            if (c == 11) bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        checks++; if (accepts !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", accepts); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_scan();
        int lat; bit scan;
        for (int i = 0; i < N_IN; i++) write_weight(i, 1);
        bus.in_valid  = 1'b1;
        bus.in_spikes = 8'hFF;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rms_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rms_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rms_busy: got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rms_in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        send_vector(8'h01, lat, scan);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rms_latency: got %0d want 1", lat); end
        checks++; if (bus.out_current !== 8'd0) begin errors++; $display("FAIL rms_cleared_weight: got %0d want 0", bus.out_current); end
        pop_output();
    endtask

    task automatic test_stats();
        int lat; bit scan;
        logic [15:0] exp_skip;
`ifdef SPARSE_STATS_EN
        exp_skip = 16'd15;
`else
        exp_skip = 16'd0;
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.skip_count !== 16'd0) begin errors++; $display("FAIL stats_cleared: got %0d want 0", bus.skip_count); end
        send_vector(8'h01, lat, scan); pop_output();
        send_vector(8'h00, lat, scan); pop_output();
        send_vector(8'hFF, lat, scan); pop_output();
        checks++; if (bus.skip_count !== exp_skip) begin errors++; $display("FAIL stats_skip_count: got %0d want %0d", bus.skip_count, exp_skip); end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_empty();
        test_clamp();
        test_backpressure();
        test_weight_write_in_scan();
        test_back_to_back();
        test_reset_mid_scan();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
